// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } arb_state_t;

  typedef logic port_t;

  localparam port_t PORT_CPU = 1'b0;
  localparam port_t PORT_DMA = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin winner pick with a registered last-served pointer.
// Latency: winner is combinational from i_req; pointer updates on i_upd.
// Backpressure: none; a losing request simply stays pending at the caller.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_upd,
  input  port_t      i_served,
  output logic [1:0] o_win
);

  port_t r_last;

  // Remember which port was served last; starts at DMA so the cpu wins the first tie.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_last <= PORT_DMA;
    end else if (i_upd) begin
      r_last <= i_served;
    end
  end

  // One-hot winner: a lone requester wins, a tie goes to the port not served last.
  always_comb begin
    o_win = 2'b00;
    case (i_req)
      2'b01:   o_win = 2'b01;
      2'b10:   o_win = 2'b10;
      2'b11:   o_win = (r_last == PORT_DMA) ? 2'b01 : 2'b10;
      default: o_win = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between cpu (port 0) and DMA/loader (port 1).
// Latency: ack two cycles after the sampling edge; one access every three cycles.
// Backpressure: losing or late requests wait, held by the requester, until the next IDLE.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        wr,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        ack,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  inout  wire  [DATA_W-1:0] mem_data
);

  arb_state_t        r_state;
  arb_state_t        w_next;
  logic [1:0]        w_win;
  port_t             w_sel;
  logic              w_upd;
  port_t             r_port;
  logic [1:0]        r_gnt;
  logic [1:0]        r_ack;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  assign w_sel = w_win[1];
  assign w_upd = (r_state == ACK);

  rr_pick2 u_pick (
    .clock    (clock),
    .reset    (reset),
    .i_req    (req),
    .i_upd    (w_upd),
    .i_served (r_port),
    .o_win    (w_win)
  );

  // Bus is driven only while the registered write enable is high, so a reset drops it at once.
  assign mem_data = r_mem_we ? r_wdata : {DATA_W{1'bz}};

  assign gnt      = r_gnt;
  assign ack      = r_ack;
  assign mem_addr = r_mem_addr;
  assign mem_we   = r_mem_we;
  assign rdata0   = r_rdata0;
  assign rdata1   = r_rdata1;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Fixed three-step schedule; only IDLE waits on a request.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (|req) ? ACCESS : IDLE;
      ACCESS:  w_next = ACK;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Latch the winner's request, run the memory cycle, then pulse ack to the owner.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_port     <= PORT_CPU;
      r_gnt      <= 2'b00;
      r_ack      <= 2'b00;
      r_mem_addr <= '0;
      r_mem_we   <= 1'b0;
      r_wdata    <= '0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_port     <= w_sel;
            r_gnt      <= w_win;
            r_mem_addr <= (w_sel == PORT_DMA) ? addr1 : addr0;
            r_mem_we   <= wr[w_sel];
            r_wdata    <= (w_sel == PORT_DMA) ? wdata1 : wdata0;
          end
        end
        ACCESS: begin
          r_mem_we <= 1'b0;
          r_ack    <= r_gnt;
          // A read captures the memory's combinational output; writes leave rdata alone.
          if (!r_mem_we) begin
            if (r_port == PORT_DMA) r_rdata1 <= mem_data;
            else                    r_rdata0 <= mem_data;
          end
        end
        ACK: begin
          r_ack <= 2'b00;
          r_gnt <= 2'b00;
        end
        default: begin
          r_ack <= 2'b00;
          r_gnt <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 256x8 memory on the shared bus.
module tb_mem_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] wr = 2'b00;
  logic [7:0] addr0 = 8'h00;
  logic [7:0] addr1 = 8'h00;
  logic [7:0] wdata0 = 8'h00;
  logic [7:0] wdata1 = 8'h00;
  wire  [1:0] gnt;
  wire  [1:0] ack;
  wire  [7:0] rdata0;
  wire  [7:0] rdata1;
  wire  [7:0] mem_addr;
  wire        mem_we;
  wire  [7:0] mem_data;

  logic [7:0] mem_arr [256];
  int checks = 0;
  int failures = 0;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .wr       (wr),
    .addr0    (addr0),
    .addr1    (addr1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .gnt      (gnt),
    .ack      (ack),
    .rdata0   (rdata0),
    .rdata1   (rdata1),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_data (mem_data)
  );

  always #5 clock = ~clock;

  // Memory model: combinational read onto the bus when not writing, write on the rising edge.
  assign mem_data = mem_we ? 8'hzz : mem_arr[mem_addr];
  always @(posedge clock) begin
    if (mem_we) mem_arr[mem_addr] <= mem_data;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_ack(input int port, output int cyc);
    cyc = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (ack[port]) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req = 2'b00;
    repeat (2) @(negedge clock);
    checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
    checks++; if (ack !== 2'b00) begin failures++; $display("FAIL reset_ack: got %b expected 00", ack); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_we: got %b expected 0", mem_we); end
    checks++; if (mem_addr !== 8'h00) begin failures++; $display("FAIL reset_addr: got %h expected 00", mem_addr); end
    checks++; if (rdata0 !== 8'h00 || rdata1 !== 8'h00) begin failures++; $display("FAIL reset_rdata: got %h/%h expected 00/00", rdata0, rdata1); end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_cpu_write();
    int cyc;
    req = 2'b01; wr = 2'b01; addr0 = 8'hF3; wdata0 = 8'h5A;
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL wr_we_before: got %b expected 0", mem_we); end
    @(negedge clock);
    checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL wr_gnt: got %b expected 01", gnt); end
    checks++; if (mem_we !== 1'b1 || mem_addr !== 8'hF3) begin failures++; $display("FAIL wr_bus: got we=%b addr=%h expected we=1 addr=F3", mem_we, mem_addr); end
    checks++; if (mem_data !== 8'h5A) begin failures++; $display("FAIL wr_data: got %h expected 5A", mem_data); end
    checks++; if (ack !== 2'b00) begin failures++; $display("FAIL wr_ack_early: got %b expected 00", ack); end
    @(negedge clock);
    checks++; if (ack !== 2'b01) begin failures++; $display("FAIL wr_ack: got %b expected 01", ack); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL wr_we_one_cycle: got %b expected 0", mem_we); end
    req = 2'b00;
    @(negedge clock);
    checks++; if (ack !== 2'b00 || gnt !== 2'b00) begin failures++; $display("FAIL wr_idle: got ack=%b gnt=%b expected 00/00", ack, gnt); end
    checks++; if (mem_arr[8'hF3] !== 8'h5A) begin failures++; $display("FAIL wr_commit: got %h expected 5A", mem_arr[8'hF3]); end
    req = 2'b01; wr = 2'b00; addr0 = 8'hF3;
    wait_ack(0, cyc);
    req = 2'b00;
    checks++; if (cyc !== 2) begin failures++; $display("FAIL rd_back_latency: got %0d expected 2", cyc); end
    checks++; if (rdata0 !== 8'h5A) begin failures++; $display("FAIL rd_back_data: got %h expected 5A", rdata0); end
    @(negedge clock);
  endtask

  task automatic test_dma_read();
    mem_arr[8'h10] = 8'hC7;
    req = 2'b10; wr = 2'b00; addr1 = 8'h10;
    @(negedge clock);
    checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL dma_gnt: got %b expected 10", gnt); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL dma_we: got %b expected 0", mem_we); end
    checks++; if (mem_data !== 8'hC7) begin failures++; $display("FAIL dma_bus: got %h expected C7", mem_data); end
    @(negedge clock);
    checks++; if (ack !== 2'b10) begin failures++; $display("FAIL dma_ack: got %b expected 10", ack); end
    checks++; if (rdata1 !== 8'hC7) begin failures++; $display("FAIL dma_rdata1: got %h expected C7", rdata1); end
    checks++; if (rdata0 !== 8'h5A) begin failures++; $display("FAIL dma_rdata0: got %h expected 5A", rdata0); end
    req = 2'b00;
    @(negedge clock);
  endtask

  task automatic test_tie_after_reset();
    int t0 = -1;
    int t1 = -1;
    pulse_reset();
    req = 2'b11; wr = 2'b00; addr0 = 8'hF3; addr1 = 8'h10;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      checks++; if (!$onehot0(gnt)) begin failures++; $display("FAIL tie_onehot: got %b at cycle %0d expected at most one bit", gnt, k); end
      if (ack[0] && t0 < 0) t0 = k;
      if (ack[1] && t1 < 0) t1 = k;
      if (ack[0]) req[0] = 1'b0;
      if (ack[1]) req[1] = 1'b0;
    end
    checks++; if (t0 !== 2) begin failures++; $display("FAIL tie_first: got port0 ack at %0d expected 2", t0); end
    checks++; if (t1 !== 5) begin failures++; $display("FAIL tie_second: got port1 ack at %0d expected 5", t1); end
    checks++; if (rdata0 !== 8'h5A || rdata1 !== 8'hC7) begin failures++; $display("FAIL tie_rdata: got %h/%h expected 5A/C7", rdata0, rdata1); end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int last_ack[2];
    int port;
    pulse_reset();
    last_ack[0] = 0;
    last_ack[1] = 0;
    req = 2'b11; wr = 2'b00; addr0 = 8'hF3; addr1 = 8'h10;
    for (int cyc = 1; cyc <= 40 && n < 6; cyc++) begin
      @(negedge clock);
      if (ack != 2'b00) begin
        port = ack[1] ? 1 : 0;
        checks++; if (!$onehot(ack)) begin failures++; $display("FAIL b2b_ack_onehot: got %b expected one-hot", ack); end
        checks++; if (port != (n % 2)) begin failures++; $display("FAIL b2b_order: got port %0d at grant %0d expected %0d", port, n, n % 2); end
        checks++; if (cyc - last_ack[port] > 6) begin failures++; $display("FAIL b2b_wait: got %0d cycles for port %0d expected <= 6", cyc - last_ack[port], port); end
        last_ack[port] = cyc;
        n++;
      end
    end
    req = 2'b00;
    checks++; if (n != 6) begin failures++; $display("FAIL b2b_count: got %0d accesses expected 6", n); end
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset_mid_write();
    int cyc;
    mem_arr[8'h20] = 8'h00;
    req = 2'b01; wr = 2'b01; addr0 = 8'h20; wdata0 = 8'hAA;
    @(posedge clock);
    #2;
    checks++; if (mem_we !== 1'b1 || gnt !== 2'b01) begin failures++; $display("FAIL rst_pre: got we=%b gnt=%b expected 1/01", mem_we, gnt); end
    reset = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_we_async: got %b expected 0", mem_we); end
    checks++; if (gnt !== 2'b00 || ack !== 2'b00) begin failures++; $display("FAIL rst_outs: got gnt=%b ack=%b expected 00/00", gnt, ack); end
    checks++; if (mem_addr !== 8'h00 || rdata0 !== 8'h00 || rdata1 !== 8'h00) begin failures++; $display("FAIL rst_vals: got addr=%h rd=%h/%h expected 00 00/00", mem_addr, rdata0, rdata1); end
    req = 2'b00;
    @(posedge clock);
    #1;
    checks++; if (mem_arr[8'h20] !== 8'h00) begin failures++; $display("FAIL rst_no_commit: got %h expected 00", mem_arr[8'h20]); end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++; if (gnt !== 2'b00 || ack !== 2'b00 || mem_we !== 1'b0) begin failures++; $display("FAIL rst_release: got gnt=%b ack=%b we=%b expected idle", gnt, ack, mem_we); end
    req = 2'b01; wr = 2'b00; addr0 = 8'h20;
    wait_ack(0, cyc);
    req = 2'b00;
    checks++; if (cyc !== 2) begin failures++; $display("FAIL rst_idle_latency: got %0d expected 2", cyc); end
    checks++; if (rdata0 !== 8'h00) begin failures++; $display("FAIL rst_readback: got %h expected 00", rdata0); end
    @(negedge clock);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = 8'h00;
    test_reset();
    test_cpu_write();
    test_dma_read();
    test_tie_after_reset();
    test_back_to_back();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter that shares the single-port 8-bit `mem` (combinational read, write on clock edge) between the `cpu` and a second master: a DMA or program loader. It sits between both masters and `mem`, owning `mem`'s `address`, `we` and bidirectional `data` pins. Each access is latched, performed and then acknowledged on a fixed 3-cycle schedule, so neither master ever drives `mem` directly.

## Interface
- `ADDR_W`, default 8: address width; matches `mem` address.
- `DATA_W`, default 8: data width; matches `mem` data.
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req[1:0]`  in  2  access request per port; port 0 = cpu, port 1 = DMA/loader.
- `wr[1:0]`  in  2  per-port write flag (1 = write, 0 = read), valid while `req`.
- `addr0`, `addr1`  in  ADDR_W  per-port address, held stable while `req`.
- `wdata0`, `wdata1`  in  DATA_W  per-port write data, held stable while `req`.
- `gnt[1:0]`  out  2  one-hot owner indicator, high for the whole transaction.
- `ack[1:0]`  out  2  one-cycle completion pulse per port.
- `rdata0`, `rdata1`  out  DATA_W  per-port registered read data.
- `mem_addr`  out  ADDR_W  to `mem` address.
- `mem_we`  out  1  to `mem` we.
- `mem_data`  inout  DATA_W  to `mem` data; driven with latched write data only when `mem_we`=1, else high-Z.

## Operation
- FSM states: IDLE, ACCESS, ACK.
- IDLE: if any `req` is high, pick a winner; latch its addr, wr and wdata; set `gnt`; go to ACCESS. If no `req` is high, stay in IDLE.
- Winner selection:
  - Only one request: that port wins.
  - Both request: the port not served last wins.
  - `last` pointer resets to 1, so port 0 wins the first tie.
- ACCESS:
  - `mem_addr` = latched address.
  - `mem_we` = latched wr.
  - `mem_data` driven when writing.
  - At the clock edge ending ACCESS: a write commits in `mem`; a read captures `mem_data` into the winner's `rdata`.
  - Then go to ACK.
- ACK:
  - `ack[winner]`=1; `last` ← winner; `gnt` stays set.
  - Go to IDLE; `gnt` clears on entry to IDLE.
- A loser's `req` stays pending; it wins the next IDLE cycle in which it is the only request, or in which it was not served last.
- Requester rule: hold `req`/`wr`/`addr`/`wdata` stable until `ack` is sampled high, then drop `req` at that same edge, or re-raise it for a new access.
- Only the winner's `rdata` register changes. A write leaves both `rdata` registers unchanged.
- Reset (async, `reset`=0), in any state:
  - State → IDLE; `gnt`=0, `ack`=0, `mem_we`=0, `mem_data`=Z, `mem_addr`=0, `rdata0`=`rdata1`=0, `last`=1.
  - A write in ACCESS that is cut by reset does not commit, because `mem_we` drops asynchronously.

## Timing
- The request is sampled at edge E0 (IDLE). `gnt` and `mem_*` are valid in cycle E0..E1 (ACCESS).
- The write commits and read data is captured at E1. `ack` and `rdata` are valid in cycle E1..E2. State is IDLE again after E2.
- Latency from a sampled `req` to `ack` high: 2 cycles. Throughput: 1 access per 3 cycles.
- Outputs `gnt`, `ack`, `mem_addr`, `mem_we` and `rdata` are registered; no combinational path from `req` to any output.
- `mem_data` tri-state enable equals registered `mem_we`, so there is no bus contention with `mem`.
- `req` asserted during ACCESS or ACK from a non-owner is ignored until the next IDLE. It is not lost as long as it stays high.

## Structure
- Package `mem_arb_pkg`: `arb_state_t` enum {IDLE, ACCESS, ACK}; `port_t` (1-bit port index); constants `PORT_CPU`=0, `PORT_DMA`=1.
- Sub-module `rr_pick2`: holds the `last` register and computes the one-hot winner from `req` and `last`. It has an update strobe, asserted in ACK, and the same async active-low reset.
- Top level: FSM, latched request, `mem` bus drive and `rdata` registers.

## Test plan
- Single cpu write:
  - Stimulus: `req`=01, `wr0`=1, `addr0`=F3, `wdata0`=5A.
  - Required: `mem_we`=1 for exactly 1 cycle with `mem_addr`=F3; `ack`=01 two cycles after the request edge; a later read of F3 returns 5A.
- Single DMA read:
  - Stimulus: `mem[10]`=C7, `req`=10, `wr1`=0, `addr1`=10.
  - Required: `rdata1`=C7 together with `ack`=10; `rdata0` unchanged; `mem_data` never driven by the arbiter.
- Tie right after reset:
  - Stimulus: `req`=11, both reads.
  - Required: port 0 is acked first, port 1 is acked 3 cycles later, and `gnt` is one-hot throughout.
- Sustained contention:
  - Stimulus: both ports re-raise `req` immediately after each `ack` for 6 accesses.
  - Required: grants alternate 0,1,0,1,0,1 and no port waits more than 6 cycles.
- Reset mid-write:
  - Stimulus: assert `reset`=0 during ACCESS of a write of AA to 20 (previously 00).
  - Required: `mem_we` drops immediately, `mem[20]` stays 00, all outputs hold their reset values, and state is IDLE after `reset` is released.
